// File: rtl/mcp3202_pkg.sv
// Shared state encoding, protocol constants and clock-derived timing helpers
// for the MCP3202 sampler.
package mcp3202_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HI,
    SCK_LO,
    HOLD,
    DONE
  } state_e;

  localparam int SCK_HZ   = 500_000;
  localparam int SPS      = 500;
  localparam int NBITS    = 12;
  localparam int NSCK     = 17;
  localparam int CMD_BITS = 4;

  // Clock cycles per SCK half period.
  function automatic int half_cycles(input int fclk);
    return fclk / (2 * SCK_HZ);
  endfunction

  // Clock cycles between conversion starts.
  function automatic int frame_cycles(input int fclk);
    return fclk / SPS;
  endfunction

endpackage

// File: rtl/mcp3202_tick_gen.sv
// Free-running frame counter (start pulse on wrap) and a clearable SCK half-period tick.
// Both outputs are combinational decodes of the counters; no backpressure.
module mcp3202_tick_gen #(
  parameter int HALF  = 100,
  parameter int FRAME = 200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic half_clr_i,
  output logic frame_start_o,
  output logic half_tick_o
);

  localparam int FW = $clog2(FRAME);
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(HALF - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [HW-1:0] half_cnt_q, half_cnt_d;

  always_comb begin
    frame_start_o = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d   = frame_start_o ? '0 : frame_cnt_q + FW'(1);

    // Held at zero while cleared so every state starts a fresh half period.
    half_tick_o = !half_clr_i && (half_cnt_q == HALF_LAST);
    if (half_clr_i || half_tick_o) begin
      half_cnt_d = '0;
    end else begin
      half_cnt_d = half_cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      half_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      half_cnt_q  <= half_cnt_d;
    end
  end

endmodule

// File: rtl/mcp3202_spi_sampler.sv
// SPI master for the MCP3202: one conversion per frame, 12-bit result with a one-cycle dv.
// Define MCP3202_NULL_CHECK_EN to add the sticky null_err output.
module mcp3202_spi_sampler
  import mcp3202_pkg::*;
#(
  parameter int   FCLK = 100_000_000,
  parameter logic SGL  = 1'b1,
  parameter logic ODD  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miso,
  output logic             mosi,
  output logic             sck,
  output logic             cs,
  output logic [NBITS-1:0] data,
  output logic             dv
`ifdef MCP3202_NULL_CHECK_EN
  ,
  output logic             null_err
`endif
);

  localparam int HALF  = half_cycles(FCLK);
  localparam int FRAME = frame_cycles(FCLK);
  localparam int EW    = $clog2(NSCK + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(NSCK);
  localparam logic [EW-1:0] DATA_EDGE = EW'(NSCK - NBITS + 1);
  localparam logic [CMD_BITS-1:0] CMD = {1'b1, SGL, ODD, 1'b1};

  state_e             state_q, state_d;
  logic [EW-1:0]      edge_q, edge_d;
  logic [CMD_BITS-1:0] cmd_q, cmd_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic [NBITS-1:0]   data_q, data_d;
  logic               cs_q, cs_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               dv_q, dv_d;
  logic               sck_rise;
  logic               frame_start;
  logic               half_tick;
  logic               half_clr;

  assign half_clr = (state_q == IDLE) || (state_q == DONE);

  mcp3202_tick_gen #(
    .HALF  (HALF),
    .FRAME (FRAME)
  ) u_tick_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .half_clr_i    (half_clr),
    .frame_start_o (frame_start),
    .half_tick_o   (half_tick)
  );

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    cmd_d    = cmd_q;
    mosi_d   = mosi_q;
    shift_d  = shift_q;
    data_d   = data_q;
    sck_rise = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SETUP;
          mosi_d  = CMD[CMD_BITS-1];
          cmd_d   = {CMD[CMD_BITS-2:0], 1'b0};
        end
      end
      SETUP: begin
        if (half_tick) begin
          state_d  = SCK_HI;
          edge_d   = EW'(1);
          sck_rise = 1'b1;
        end
      end
      SCK_HI: begin
        // Falling edge: present the bit for the next rising edge; zeros once the command is spent.
        if (half_tick) begin
          state_d = SCK_LO;
          mosi_d  = cmd_q[CMD_BITS-1];
          cmd_d   = {cmd_q[CMD_BITS-2:0], 1'b0};
        end
      end
      SCK_LO: begin
        if (half_tick) begin
          if (edge_q == LAST_EDGE) begin
            state_d = HOLD;
            data_d  = shift_q;
          end else begin
            state_d  = SCK_HI;
            edge_d   = edge_q + EW'(1);
            sck_rise = 1'b1;
          end
        end
      end
      HOLD: begin
        if (half_tick) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Only the B11..B0 window is captured, so miso is don't-care everywhere else.
    if (sck_rise && (edge_d >= DATA_EDGE)) begin
      shift_d = {shift_q[NBITS-2:0], miso};
    end

    cs_d  = !((state_d == SETUP) || (state_d == SCK_HI) ||
              (state_d == SCK_LO) || (state_d == HOLD));
    sck_d = (state_d == SCK_HI);
    dv_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      edge_q  <= '0;
      cmd_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      cmd_q   <= cmd_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dv_q    <= dv_d;
    end
  end

  assign cs   = cs_q;
  assign sck  = sck_q;
  assign mosi = mosi_q;
  assign data = data_q;
  assign dv   = dv_q;

`ifdef MCP3202_NULL_CHECK_EN
  localparam logic [EW-1:0] NULL_EDGE = EW'(NSCK - NBITS);

  logic null_err_q, null_err_d;

  always_comb begin
    null_err_d = null_err_q;
    if (sck_rise && (edge_d == NULL_EDGE) && miso) begin
      null_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      null_err_q <= 1'b0;
    end else begin
      null_err_q <= null_err_d;
    end
  end

  assign null_err = null_err_q;
`endif

endmodule

// File: tb/tb_mcp3202_spi_sampler.sv
// Bench for mcp3202_spi_sampler: behavioural MCP3202 driving miso, frame timing and data checks.
`timescale 1ns/1ps
module tb_mcp3202_spi_sampler;

  localparam int     FCLK     = 10_000_000;
  localparam logic   SGL      = 1'b1;
  localparam logic   ODD      = 1'b0;
  localparam longint TCLK     = 1_000_000_000 / FCLK;
  localparam longint SCK_NS   = 1_000_000_000 / 500_000;
  localparam longint HALF_NS  = SCK_NS / 2;
  localparam longint FRAME_NS = 1_000_000_000 / 500;
  localparam int     BUDGET   = int'(FRAME_NS / TCLK) + 500;

  logic        clk, rst_n, miso, mosi, sck, cs, dv;
  logic [11:0] data;

  mcp3202_spi_sampler #(.FCLK(FCLK), .SGL(SGL), .ODD(ODD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .miso  (miso),
    .mosi  (mosi),
    .sck   (sck),
    .cs    (cs),
    .data  (data),
    .dv    (dv)
  );

  int total, bad;
  longint t_rel, t_fall, t_prev, t_csrise;
  longint t_rise [32];
  logic   mosi_at [32];
  int rises, dv_cnt, dv_cslow, idle_bad, frame_done;
  logic dv_at_csrise;
  logic [11:0] data_at_dv, data_at_fall, adc_val, exp_val;
  int fall_n;

  initial begin
    clk = 1'b0;
    forever #(TCLK / 2) clk = ~clk;
  end

  // MCP3202 model: null bit after falling edge 4, B11..B0 after falling edges 5..16.
  initial begin
    miso = 1'bz;
    forever begin
      @(negedge cs);
      fall_n = 0;
      miso = 1'bx;
      while (cs == 1'b0) begin
        @(negedge sck or posedge cs);
        if (cs == 1'b0) begin
          fall_n++;
          if (fall_n == 4) miso = 1'b0;
          else if (fall_n >= 5 && fall_n <= 16) miso = adc_val[4'(16 - fall_n)];
          else miso = 1'bx;
        end
      end
      miso = 1'bz;
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input longint obs, input longint lo, input longint hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Watches one frame from cs fall to two cycles after cs rise (or until stop_rises sck rises).
  task automatic obs_frame(input int stop_rises);
    logic pcs, psck;
    bit fallen, rose;
    int after;
    pcs = cs; psck = sck; fallen = 0; rose = 0; after = 0;
    rises = 0; dv_cnt = 0; dv_cslow = 0; idle_bad = 0; frame_done = 0;
    for (int c = 0; c < BUDGET && frame_done == 0; c++) begin
      @(negedge clk);
      if (!fallen) begin
        if (cs == 1'b0 && pcs == 1'b1) begin
          fallen = 1; t_fall = longint'($time); data_at_fall = data;
        end else if (sck !== 1'b0 || mosi !== 1'b0 || dv !== 1'b0 || cs !== 1'b1) begin
          idle_bad++;
        end
      end
      if (fallen && !rose) begin
        if (sck && !psck) begin
          if (rises < 32) begin
            t_rise[rises] = longint'($time);
            mosi_at[rises] = mosi;
          end
          rises++;
          if (rises == stop_rises) frame_done = 1;
        end
        if (cs && !pcs) begin
          rose = 1; t_csrise = longint'($time); dv_at_csrise = dv; data_at_dv = data;
        end
      end else if (rose) begin
        after++;
        if (after == 2) frame_done = 1;
      end
      if (dv) begin
        dv_cnt++;
        if (!cs) dv_cslow++;
      end
      pcs = cs; psck = sck;
    end
  endtask

  initial begin
    logic exp_cmd [4];
    int late_bad, period_bad, n_dv, n_cs;
    total = 0; bad = 0;
    exp_cmd = '{1'b1, SGL, ODD, 1'b1};
    adc_val = 12'h5DC;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    check_eq("rst_cs", longint'(cs), 1);
    check_eq("rst_sck", longint'(sck), 0);
    check_eq("rst_mosi", longint'(mosi), 0);
    check_eq("rst_data", longint'(data), 0);
    check_eq("rst_dv", longint'(dv), 0);
    #13 rst_n = 1'b1;
    t_rel = longint'($time);

    // Frame 1: fixed 0x5DC sample.
    obs_frame(0);
    check_eq("f1_done", longint'(frame_done), 1);
    check_eq("f1_idle_outputs", longint'(idle_bad), 0);
    check_range("f1_first_start_ns", t_fall - t_rel, FRAME_NS - TCLK, FRAME_NS + TCLK);
    check_range("f1_cs_high_ns", t_fall - t_rel, 500, FRAME_NS + TCLK);
    check_eq("f1_setup_ns", t_rise[0] - t_fall, HALF_NS);
    for (int i = 0; i < 4; i++) check_eq($sformatf("f1_mosi_edge%0d", i + 1), longint'(mosi_at[i]), longint'(exp_cmd[i]));
    late_bad = 0;
    for (int i = 4; i < 17; i++) if (mosi_at[i] !== 1'b0) late_bad++;
    check_eq("f1_mosi_tail_nonzero", longint'(late_bad), 0);
    check_eq("f1_sck_period_ns", t_rise[1] - t_rise[0], SCK_NS);
    period_bad = 0;
    for (int i = 1; i < 17; i++) if (t_rise[i] - t_rise[i-1] != SCK_NS) period_bad++;
    check_eq("f1_sck_period_irregular", longint'(period_bad), 0);
    check_eq("f1_sck_pulses", longint'(rises), 17);
    check_eq("f1_active_ns", t_csrise - t_fall, 36 * HALF_NS);
    check_eq("f1_dv_at_cs_rise", longint'(dv_at_csrise), 1);
    check_eq("f1_dv_pulses", longint'(dv_cnt), 1);
    check_eq("f1_dv_while_cs_low", longint'(dv_cslow), 0);
    check_eq("f1_data", longint'(data_at_dv), longint'(12'h5DC));

    // Frame 2: random sample, start spacing and held data.
    exp_val = data_at_dv;
    t_prev = t_fall;
    adc_val = 12'($urandom);
    obs_frame(0);
    check_eq("f2_done", longint'(frame_done), 1);
    check_eq("f2_spacing_ns", t_fall - t_prev, FRAME_NS);
    check_eq("f2_data_held", longint'(data_at_fall), longint'(exp_val));
    check_eq("f2_sck_pulses", longint'(rises), 17);
    check_eq("f2_dv_pulses", longint'(dv_cnt), 1);
    check_eq("f2_data", longint'(data_at_dv), longint'(adc_val));

    // Frame 3: reset after sck pulse 8.
    t_prev = t_fall;
    adc_val = 12'($urandom);
    obs_frame(8);
    check_eq("f3_done", longint'(frame_done), 1);
    check_eq("f3_spacing_ns", t_fall - t_prev, FRAME_NS);
    check_eq("f3_dv_before_abort", longint'(dv_cnt), 0);
    for (int c = 0; c < 64 && sck; c++) @(negedge clk);
    check_eq("f3_pulse8_ended", longint'(sck), 0);
    #7 rst_n = 1'b0;
    #1;
    check_eq("abort_cs", longint'(cs), 1);
    check_eq("abort_sck", longint'(sck), 0);
    check_eq("abort_mosi", longint'(mosi), 0);
    check_eq("abort_dv", longint'(dv), 0);
    check_eq("abort_data", longint'(data), 0);
    #25 rst_n = 1'b1;
    n_dv = 0; n_cs = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (dv) n_dv++;
      if (!cs || data !== 12'h000) n_cs++;
    end
    check_eq("post_abort_dv", longint'(n_dv), 0);
    check_eq("post_abort_cs_or_data", longint'(n_cs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
